// File: rtl/operand_stage.sv
// operand_stage: ID->EX pipeline register of the RV32 core.
//
// Drives the register-file read addresses straight from the decoded
// instruction, resolves each source operand (x0 forced to zero, same-cycle
// writeback bypass) and captures the result into the EX-side register.
// A load held in EX whose rd is read by the instruction waiting in ID
// causes a single bubble; the load value itself is forwarded later in EX.
//
// Ports
//   clk_i, reset_n_i           clock, synchronous active-low reset
//   id_valid_i / id_ready_o    decode handshake
//   id_pc_i, id_imm_i          PC and immediate of the decoded instruction
//   id_rs1_i, id_rs2_i, id_rd_i, id_uses_rs1_i, id_uses_rs2_i,
//   id_rd_we_i, id_is_load_i   register usage of the decoded instruction
//   rf_rs1_o, rf_rs2_o         register-file read addresses
//   rf_data_rs1_i/rs2_i        register-file read data
//   wb_we_i, wb_rd_i, wb_data_i  writeback port (also writes the regfile)
//   flush_i                    kill held and incoming instruction
//   ex_valid_o / ex_ready_i    execute handshake
//   ex_pc_o, ex_imm_o, ex_op1_o, ex_op2_o, ex_rd_o, ex_rd_we_o,
//   ex_is_load_o               captured payload
//   load_use_stall_o           status: load-use stall in progress
//
// State | meaning
// EMPTY | no instruction held, ex_valid_o = 0
// FULL  | instruction held for EX, ex_valid_o = 1
module operand_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            id_valid_i,
  output logic            id_ready_o,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [4:0]      id_rs1_i,
  input  logic [4:0]      id_rs2_i,
  input  logic [4:0]      id_rd_i,
  input  logic            id_uses_rs1_i,
  input  logic            id_uses_rs2_i,
  input  logic            id_rd_we_i,
  input  logic            id_is_load_i,
  output logic [4:0]      rf_rs1_o,
  output logic [4:0]      rf_rs2_o,
  input  logic [XLEN-1:0] rf_data_rs1_i,
  input  logic [XLEN-1:0] rf_data_rs2_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            flush_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [XLEN-1:0] ex_op1_o,
  output logic [XLEN-1:0] ex_op2_o,
  output logic [4:0]      ex_rd_o,
  output logic            ex_rd_we_o,
  output logic            ex_is_load_o,
  output logic            load_use_stall_o
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, imm_q, imm_d, op1_q, op1_d, op2_q, op2_d;
  logic [4:0]      rd_q, rd_d;
  logic            rd_we_q, rd_we_d, is_load_q, is_load_d;

  logic            ex_valid;
  logic            hazard;
  logic            advance;
  logic [XLEN-1:0] op1_res, op2_res;

  // The register file only commits a write at the clock edge, so a value
  // being written this cycle must be taken from the writeback port.
  function automatic logic [XLEN-1:0] resolve(input logic [4:0]      rs,
                                              input logic [XLEN-1:0] rf_data,
                                              input logic            we,
                                              input logic [4:0]      wrd,
                                              input logic [XLEN-1:0] wdata);
    if (rs == 5'd0)
      return '0;
    else if (we && (wrd == rs))
      return wdata;
    else
      return rf_data;
  endfunction

  assign rf_rs1_o = id_rs1_i;
  assign rf_rs2_o = id_rs2_i;

  assign op1_res = resolve(id_rs1_i, rf_data_rs1_i, wb_we_i, wb_rd_i, wb_data_i);
  assign op2_res = resolve(id_rs2_i, rf_data_rs2_i, wb_we_i, wb_rd_i, wb_data_i);

  assign ex_valid = (state_q == FULL);

  // Deliberately independent of id_valid_i so id_ready_o has no path from it.
  assign hazard = ex_valid && is_load_q && rd_we_q && (rd_q != 5'd0) &&
                  ((id_uses_rs1_i && (id_rs1_i == rd_q)) ||
                   (id_uses_rs2_i && (id_rs2_i == rd_q)));

  assign advance          = !ex_valid || ex_ready_i;
  assign id_ready_o       = reset_n_i && advance && !hazard && !flush_i;
  assign load_use_stall_o = hazard && id_valid_i;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    rd_d      = rd_q;
    rd_we_d   = rd_we_q;
    is_load_d = is_load_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else if (id_valid_i && id_ready_o) begin
      state_d   = FULL;
      pc_d      = id_pc_i;
      imm_d     = id_imm_i;
      op1_d     = op1_res;
      op2_d     = op2_res;
      rd_d      = id_rd_i;
      rd_we_d   = id_rd_we_i;
      is_load_d = id_is_load_i;
    end else if (advance) begin
      // Either nothing offered or a hazard: the held payload is gone, bubble.
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= EMPTY;
      pc_q      <= '0;
      imm_q     <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      is_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      rd_q      <= rd_d;
      rd_we_q   <= rd_we_d;
      is_load_q <= is_load_d;
    end
  end

  assign ex_valid_o   = ex_valid;
  assign ex_pc_o      = pc_q;
  assign ex_imm_o     = imm_q;
  assign ex_op1_o     = op1_q;
  assign ex_op2_o     = op2_q;
  assign ex_rd_o      = rd_q;
  assign ex_rd_we_o   = rd_we_q;
  assign ex_is_load_o = is_load_q;

endmodule
